// File: rtl/c3_window_feeder_pkg.sv
// Shared constants, FSM encoding and col_out slice layout for the C3 window
// feeder and the 6-channel 5x5 convolution engine it drives.
package c3_window_feeder_pkg;

  localparam int BIT_WIDTH      = 8;
  localparam int IN_SIZE        = 14;
  localparam int K              = 5;
  localparam int CH             = 6;
  localparam int CONV_LAT_DEF   = 1;
  localparam int ADDR_WIDTH_DEF = 8;

  localparam int OUT_SIZE = IN_SIZE - K + 1;
  localparam int TAG_W    = $clog2(OUT_SIZE);
  localparam int POS_W    = $clog2(IN_SIZE);
  localparam int PIX_W    = CH * BIT_WIDTH;
  localparam int COL_W    = CH * K * BIT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Bit offset of pixel (channel c, kernel row k) inside col_out.
  function automatic int unsigned idx(input int unsigned c, input int unsigned k);
    return (c * K + k) * BIT_WIDTH;
  endfunction

endpackage

// File: rtl/c3_window_feeder_if.sv
// Buffer read port, engine column feed and window tag bundle of the C3 feeder.
interface c3_window_feeder_if
  import c3_window_feeder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PIX_W-1:0]      rd_data;
  logic                  out_ready;
  logic                  conv_en;
  logic [COL_W-1:0]      col_out;
  logic                  win_valid;
  logic [TAG_W-1:0]      win_row;
  logic [TAG_W-1:0]      win_col;

  modport master (
    output rd_en, rd_addr, conv_en, col_out, win_valid, win_row, win_col,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, conv_en, col_out, win_valid, win_row, win_col,
    output rd_data, out_ready
  );

endinterface

// File: rtl/c3_win_tag_pipe.sv
// CONV_LAT-deep shift pipe carrying (valid,row,col) window tags alongside the
// convolution engine latency.
module c3_win_tag_pipe
  import c3_window_feeder_pkg::*;
#(
  parameter int DEPTH = CONV_LAT_DEF,
  parameter int W     = TAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_row,
  input  logic [W-1:0] in_col,
  output logic         out_valid,
  output logic [W-1:0] out_row,
  output logic [W-1:0] out_col
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     rows [DEPTH];
  logic [W-1:0]     cols [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rows[i] <= '0;
        cols[i] <= '0;
      end
    end else begin
      vld[0]  <= in_valid;
      rows[0] <= in_row;
      cols[0] <= in_col;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        rows[i] <= rows[i-1];
        cols[i] <= cols[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_row   = rows[DEPTH-1];
  assign out_col   = cols[DEPTH-1];

endmodule

// File: rtl/c3_window_feeder.sv
// Streams 5-pixel columns of six 14x14 feature maps into the C3 convolution
// engine, one column per conv_en, tagging each completed 5x5 window.
module c3_window_feeder
  import c3_window_feeder_pkg::*;
#(
  parameter int CONV_LAT   = CONV_LAT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  c3_window_feeder_if.master bus
);

  localparam int CNT_MAX = (K > CONV_LAT) ? K : CONV_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_nxt;
  logic [POS_W-1:0]   row, col;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   slot;
  logic [COL_W-1:0]   col_buf;
  logic               last_col, issue, capture;
  logic               push_valid;
  logic [TAG_W-1:0]   push_row, push_col;

  assign last_col = (row == POS_W'(IN_SIZE - K)) && (col == POS_W'(IN_SIZE - 1));
  assign issue    = (state == ISSUE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (cnt == CNT_W'(K - 1)) state_nxt = CAPT;
      CAPT:    state_nxt = ISSUE;
      ISSUE:   if (bus.out_ready) state_nxt = last_col ? DRAIN : FETCH;
      DRAIN:   if (cnt == CNT_W'(CONV_LAT - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.conv_en = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      FETCH: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = (ADDR_WIDTH'(row) + ADDR_WIDTH'(cnt)) * ADDR_WIDTH'(IN_SIZE)
                    + ADDR_WIDTH'(col);
      end
      ISSUE:   bus.conv_en = bus.out_ready;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Read data lags the address by one cycle, so FETCH step k lands slot k-1
  // and the final slot is landed by the single CAPT cycle.
  assign capture = ((state == FETCH) && (cnt != '0)) || (state == CAPT);
  assign slot    = (state == CAPT) ? CNT_W'(K - 1) : cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      cnt     <= '0;
      col_buf <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row <= '0;
          col <= '0;
          cnt <= '0;
        end
        FETCH: cnt <= (cnt == CNT_W'(K - 1)) ? '0 : cnt + CNT_W'(1);
        ISSUE: if (bus.out_ready) begin
          cnt <= '0;
          if (col == POS_W'(IN_SIZE - 1)) begin
            col <= '0;
            row <= row + POS_W'(1);
          end else begin
            col <= col + POS_W'(1);
          end
        end
        DRAIN: cnt <= (cnt == CNT_W'(CONV_LAT - 1)) ? '0 : cnt + CNT_W'(1);
        default: ;
      endcase
      if (capture) begin
        for (int unsigned ch = 0; ch < CH; ch++) begin
          col_buf[idx(ch, 32'(slot)) +: BIT_WIDTH] <= bus.rd_data[ch*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  assign bus.col_out = col_buf;

  assign push_valid = issue && (col >= POS_W'(K - 1));
  assign push_row   = push_valid ? TAG_W'(row) : '0;
  assign push_col   = push_valid ? TAG_W'(col - POS_W'(K - 1)) : '0;

  c3_win_tag_pipe #(
    .DEPTH (CONV_LAT),
    .W     (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_row    (push_row),
    .in_col    (push_col),
    .out_valid (bus.win_valid),
    .out_row   (bus.win_row),
    .out_col   (bus.win_col)
  );

endmodule
